axppa_error_metrics: RTL and testbench

Downstream scoring stage for the approximate three-operand parallel-prefix adders (Kogge-Stone and siblings). Sees the same operand triples as the adder under test plus the adder's registered sum. Delay-aligns an exact reference sum to the adder's pipeline latency and accumulates error metrics over a programmed batch: error rate, maximum error distance and summed error distance. Used in self-checking characterisation runs and on-chip BIST of each AxPPA variant.

---
 rtl/axppa_pkg.sv | 24 ++
 rtl/axppa_align_pipe.sv | 49 ++++
 rtl/axppa_error_metrics.sv | 142 ++++++++++++++
 tb/tb_axppa_error_metrics.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axppa_pkg.sv
// Shared types and helpers for the AxPPA error-metrics scoring stage.
package axppa_pkg;

    // Default operand/sum width of the adders under test.
    localparam int unsigned AxppaWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Unsigned add of two values, clamped at 2^w-1 (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[63:0];
    endfunction

endpackage

// File: rtl/axppa_align_pipe.sv
// LATENCY-deep data+valid delay line; async clear, sync flush of the valid bits.
module axppa_align_pipe #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Shift valid bits; flush empties the line so stale samples are never scored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Shift data unconditionally; only the valid bits qualify it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= in_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/axppa_error_metrics.sv
// Scores an approximate adder against a delay-aligned exact sum over a batch.
module axppa_error_metrics
    import axppa_pkg::*;
#(
    parameter int unsigned WIDTH   = AxppaWidth,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       a_input,
    input  logic [WIDTH-1:0]       b_input,
    input  logic [WIDTH-1:0]       c_input,
    input  logic [WIDTH-1:0]       approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic                   err_flag,
    output logic [CNT_W-1:0]       sample_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [WIDTH-1:0]       max_ed,
    output logic [WIDTH+CNT_W-1:0] sum_ed
);

    localparam int unsigned SumW = WIDTH + CNT_W;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  sample_count_q, sample_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [WIDTH-1:0]  max_ed_q, max_ed_d;
    logic [SumW-1:0]   sum_ed_q, sum_ed_d;
    logic              err_flag_q, err_flag_d;

    logic [WIDTH-1:0]  exact_sum;
    logic              accept, flush, score;
    logic              pipe_valid;
    logic [WIDTH-1:0]  pipe_exact;
    logic [WIDTH-1:0]  ed;

    // Wraps modulo 2^WIDTH exactly like the adder under test.
    assign exact_sum = a_input + b_input + c_input;
    assign accept    = (state_q == StRun) && in_valid;
    assign flush     = (state_q == StIdle) && start;
    assign score     = pipe_valid && ((state_q == StRun) || (state_q == StDrain));
    assign ed        = (pipe_exact >= approx_sum) ? (pipe_exact - approx_sum)
                                                  : (approx_sum - pipe_exact);

    axppa_align_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_align_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (exact_sum),
        .out_valid (pipe_valid),
        .out_data  (pipe_exact)
    );

    // Batch sequencing plus metric accumulation for the sample leaving the pipe.
    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        issued_d       = issued_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        max_ed_d       = max_ed_q;
        sum_ed_d       = sum_ed_q;
        err_flag_d     = err_flag_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d          = num_samples;
                    issued_d       = '0;
                    sample_count_d = '0;
                    err_count_d    = '0;
                    max_ed_d       = '0;
                    sum_ed_d       = '0;
                    err_flag_d     = 1'b0;
                    state_d        = (num_samples == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (in_valid) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_d == num_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (sample_count_q == num_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (score) begin
            sample_count_d = sample_count_q + 1'b1;
            err_flag_d     = (ed != '0);
            if (ed != '0) err_count_d = err_count_q + 1'b1;
            if (ed > max_ed_q) max_ed_d = ed;
            sum_ed_d = SumW'(sat_add(64'(sum_ed_q), 64'(ed), SumW));
        end
    end

    // State and metric registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            num_q          <= '0;
            issued_q       <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            max_ed_q       <= '0;
            sum_ed_q       <= '0;
            err_flag_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            issued_q       <= issued_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            max_ed_q       <= max_ed_d;
            sum_ed_q       <= sum_ed_d;
            err_flag_q     <= err_flag_d;
        end
    end

    assign busy         = (state_q == StRun) || (state_q == StDrain);
    assign done         = (state_q == StDone);
    assign err_flag     = err_flag_q;
    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign max_ed       = max_ed_q;
    assign sum_ed       = sum_ed_q;

endmodule

// File: tb/tb_axppa_error_metrics.sv
// Directed bench: three DUT variants share operands; a behavioural adder feeds approx_sum.
module tb_axppa_error_metrics;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0, start4 = 1'b0;
    logic [15:0] num_samples = '0;
    logic        in_valid = 1'b0;
    logic [15:0] a_input = '0, b_input = '0, c_input = '0;

    // Adder model controls: 0 exact, 1 lsb flip, 2 +0x100 on fault_now, 3 constant 0xFFFF.
    logic [1:0]  mode = 2'd0;
    logic        fault_now = 1'b0;
    logic [15:0] model_sum, exact_m;
    logic [15:0] apipe [8];

    logic        busy1, done1, err_flag1;
    logic [15:0] sample_count1, err_count1, max_ed1;
    logic [31:0] sum_ed1;
    logic        busy3, done3, err_flag3;
    logic [15:0] sample_count3, err_count3, max_ed3;
    logic [31:0] sum_ed3;
    logic        busy4, done4, err_flag4;
    logic [3:0]  sample_count4, err_count4;
    logic [15:0] max_ed4;
    logic [19:0] sum_ed4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        exact_m = a_input + b_input + c_input;
        case (mode)
            2'd0:    model_sum = exact_m;
            2'd1:    model_sum = exact_m ^ 16'h0001;
            2'd2:    model_sum = fault_now ? exact_m + 16'h0100 : exact_m;
            default: model_sum = 16'hFFFF;
        endcase
    end

    // Registered adder pipeline model; tap k gives latency k+1.
    always @(posedge clk) begin
        apipe[0] <= model_sum;
        for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
    end

    axppa_error_metrics #(.WIDTH(16), .LATENCY(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .num_samples(num_samples),
        .in_valid(in_valid), .a_input(a_input), .b_input(b_input), .c_input(c_input),
        .approx_sum(apipe[0]), .busy(busy1), .done(done1), .err_flag(err_flag1),
        .sample_count(sample_count1), .err_count(err_count1), .max_ed(max_ed1),
        .sum_ed(sum_ed1)
    );

    axppa_error_metrics #(.WIDTH(16), .LATENCY(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .num_samples(num_samples),
        .in_valid(in_valid), .a_input(a_input), .b_input(b_input), .c_input(c_input),
        .approx_sum(apipe[2]), .busy(busy3), .done(done3), .err_flag(err_flag3),
        .sample_count(sample_count3), .err_count(err_count3), .max_ed(max_ed3),
        .sum_ed(sum_ed3)
    );

    axppa_error_metrics #(.WIDTH(16), .LATENCY(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .num_samples(num_samples[3:0]),
        .in_valid(in_valid), .a_input(a_input), .b_input(b_input), .c_input(c_input),
        .approx_sum(apipe[0]), .busy(busy4), .done(done4), .err_flag(err_flag4),
        .sample_count(sample_count4), .err_count(err_count4), .max_ed(max_ed4),
        .sum_ed(sum_ed4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;

        // Reset state
        #12;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_err_flag", 64'(err_flag1), 64'd0);
        check("rst_sample_count", 64'(sample_count1), 64'd0);
        check("rst_sum_ed", 64'(sum_ed1), 64'd0);
        reset = 1'b1;
        tick();

        // T1: exact adder, 100 samples, latency 1
        num_samples = 16'd100;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t1_busy_after_start", 64'(busy1), 64'd1);
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            a_input = 16'(5 + i);
            b_input = 16'(4 * i);
            c_input = 16'(8 * i);
            tick();
        end
        in_valid = 1'b0;
        check("t1_count_at_last_issue", 64'(sample_count1), 64'd99);
        check("t1_busy_drain", 64'(busy1), 64'd1);
        tick();
        check("t1_done_early", 64'(done1), 64'd0);
        check("t1_count_scored", 64'(sample_count1), 64'd100);
        tick();
        check("t1_done", 64'(done1), 64'd1);
        check("t1_busy_fall", 64'(busy1), 64'd0);
        check("t1_sample_count", 64'(sample_count1), 64'd100);
        check("t1_err_count", 64'(err_count1), 64'd0);
        check("t1_max_ed", 64'(max_ed1), 64'd0);
        check("t1_sum_ed", 64'(sum_ed1), 64'd0);
        check("t1_err_flag", 64'(err_flag1), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done1), 64'd0);

        // T2: lsb-flipped adder, 10 samples
        mode = 2'd1;
        num_samples = 16'd10;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_input = 16'(3 * i + 7);
            b_input = 16'(i);
            c_input = 16'h1234;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("t2_done", 64'(done1), 64'd1);
        check("t2_err_count", 64'(err_count1), 64'd10);
        check("t2_max_ed", 64'(max_ed1), 64'd1);
        check("t2_sum_ed", 64'(sum_ed1), 64'd10);
        check("t2_err_flag", 64'(err_flag1), 64'd1);
        mode = 2'd0;
        tick();

        // T3: latency 3, single fault on sample 3, in_valid every other cycle
        mode = 2'd2;
        num_samples = 16'd6;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            fault_now = (i == 3);
            a_input = 16'(i);
            b_input = 16'(2 * i);
            c_input = 16'd0;
            tick();
            if (i == 4) check("t3_err_not_yet", 64'(err_count3), 64'd0);
            in_valid = 1'b0;
            fault_now = 1'b0;
            tick();
            if (i == 4) begin
                check("t3_err_at_lat3", 64'(err_count3), 64'd1);
                check("t3_flag_at_lat3", 64'(err_flag3), 64'd1);
                check("t3_max_at_lat3", 64'(max_ed3), 64'd256);
            end
            if (i == 5) begin
                check("t3_flag_cleared", 64'(err_flag3), 64'd0);
                check("t3_count_mid", 64'(sample_count3), 64'd5);
            end
        end
        tick();
        tick();
        check("t3_done_early", 64'(done3), 64'd0);
        tick();
        check("t3_done", 64'(done3), 64'd1);
        check("t3_sample_count", 64'(sample_count3), 64'd6);
        check("t3_err_count", 64'(err_count3), 64'd1);
        check("t3_max_ed", 64'(max_ed3), 64'd256);
        check("t3_sum_ed", 64'(sum_ed3), 64'd256);
        mode = 2'd0;
        tick();

        // T4: empty batch
        num_samples = 16'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t4_done", 64'(done1), 64'd1);
        check("t4_busy", 64'(busy1), 64'd0);
        check("t4_err_count_cleared", 64'(err_count1), 64'd0);
        check("t4_sum_ed_cleared", 64'(sum_ed1), 64'd0);
        check("t4_err_flag_cleared", 64'(err_flag1), 64'd0);
        tick();
        check("t4_done_pulse", 64'(done1), 64'd0);
        check("t4_busy_after", 64'(busy1), 64'd0);

        // T5: in_valid with start, start during RUN, extra in_valid after batch
        num_samples = 16'd4;
        start1 = 1'b1;
        in_valid = 1'b1;
        a_input = 16'd100;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            start1 = (i == 1);
            a_input = 16'(200 + i);
            tick();
        end
        start1 = 1'b0;
        mode = 2'd1;
        tick();
        check("t5_done_early", 64'(done1), 64'd0);
        tick();
        check("t5_done", 64'(done1), 64'd1);
        check("t5_sample_count", 64'(sample_count1), 64'd4);
        check("t5_err_count", 64'(err_count1), 64'd0);
        in_valid = 1'b0;
        mode = 2'd0;
        tick();
        check("t5_count_hold", 64'(sample_count1), 64'd4);

        // T6: CNT_W=4, every sample at ED=0xFFFF
        mode = 2'd3;
        a_input = '0;
        b_input = '0;
        c_input = '0;
        num_samples = 16'd15;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_done", 64'(done4), 64'd1);
        check("t6_sample_count", 64'(sample_count4), 64'd15);
        check("t6_err_count", 64'(err_count4), 64'd15);
        check("t6_max_ed", 64'(max_ed4), 64'hFFFF);
        check("t6_sum_ed", 64'(sum_ed4), 64'd983025);
        mode = 2'd0;
        tick();

        // T7: reset during DRAIN, then a clean batch
        mode = 2'd1;
        num_samples = 16'd2;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_input = 16'(50 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("t7_pre_reset_err", 64'(err_count3), 64'd1);
        check("t7_pre_reset_busy", 64'(busy3), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t7_rst_busy", 64'(busy3), 64'd0);
        check("t7_rst_done", 64'(done3), 64'd0);
        check("t7_rst_err_flag", 64'(err_flag3), 64'd0);
        check("t7_rst_sample_count", 64'(sample_count3), 64'd0);
        check("t7_rst_err_count", 64'(err_count3), 64'd0);
        check("t7_rst_max_ed", 64'(max_ed3), 64'd0);
        check("t7_rst_sum_ed", 64'(sum_ed3), 64'd0);
        reset = 1'b1;
        mode = 2'd0;
        tick();
        tick();
        check("t7_idle_after_reset", 64'(busy3), 64'd0);
        num_samples = 16'd3;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a_input = 16'(900 + i);
            b_input = 16'(i);
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("t7_done_latency", 64'(n), 64'd4);
        check("t7_sample_count", 64'(sample_count3), 64'd3);
        check("t7_err_count", 64'(err_count3), 64'd0);
        check("t7_sum_ed", 64'(sum_ed3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
